serial_word_receiver: RTL and testbench
=======================================

Name: serial_word_receiver

Overview:
Receiving end of the shift-enable serial link: deserializes the bit stream qualified by the 4-cycle Sh burst from the shift controller. Samples sin on every clock edge where sh is high, assembles WIDTH bits into a parallel word, and presents it on a valid/ready output port. Detects truncated bursts (framing error) and words lost to a stalled consumer (overrun). Sits between the serial shifter datapath and the parallel consumer logic.

Parameters:
WIDTH, 4, bits per frame; equals the sh burst length; legal range 2..32
LSB_FIRST, 1, 1 = first sampled bit is dout[0]; 0 = first sampled bit is dout[WIDTH-1]

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset, synchronous, active-high
sh  input  1  shift enable from the transmitter; one frame = WIDTH consecutive high cycles
sin  input  1  serial data; valid only when sh=1
dout  output  WIDTH  assembled word; stable while dout_valid=1
dout_valid  output  1  word available
dout_ready  input  1  consumer accepts dout on an edge where dout_valid&dout_ready
busy  output  1  frame in progress (1..WIDTH-1 bits captured)
frame_err  output  1  one-cycle pulse: burst ended early
overrun  output  1  one-cycle pulse: completed word dropped

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, bit count=0, shift reg=0, dout=0, dout_valid=0, busy=0, frame_err=0, overrun=0. Reset overrides all other inputs, including mid-frame; partial frame discarded, no error pulse.
- States: IDLE (count=0), SHIFT (count 1..WIDTH-1). Registered, count is clog2(WIDTH+1) bits.
- IDLE, sh=1: capture sin as bit 0 of frame, count=1, go SHIFT. IDLE, sh=0: no change.
- SHIFT, sh=1, count<WIDTH-1: capture sin, count++.
- SHIFT, sh=1, count=WIDTH-1: capture final bit, word complete, count=0, go IDLE. Same edge: completed word delivered per output rules below.
- SHIFT, sh=0: frame_err=1 for the next cycle, shift reg cleared, count=0, go IDLE.
- Back-to-back frames: sh held high past WIDTH cycles starts a new frame on the next cycle with no gap; no error.
- Bit order: LSB_FIRST=1 shifts right-in from MSB so first bit lands at dout[0]; LSB_FIRST=0 shifts left so first bit lands at dout[WIDTH-1].
- Latency: dout_valid rises on the same posedge that samples the last bit (visible the cycle after the last sh-high cycle).
- Output on completion edge: if dout_valid=0 or dout_ready=1, load dout, dout_valid=1. If dout_valid=1 and dout_ready=0, keep old dout, drop new word, pulse overrun for 1 cycle.
- Without completion: dout_valid&dout_ready clears dout_valid; dout holds last value.
- busy = (state==SHIFT), registered.
- frame_err and overrun are never both asserted by the same edge (completion and truncation are exclusive).

Decomposition:
- Shared package serial_link_pkg: state encoding constants (ST_IDLE=0, ST_SHIFT=1), default frame width constant FRAME_BITS=4, shared with the shift controller.
- One natural sub-module: serial_out_buffer (single-entry valid/ready holding register with overrun detect); the shift/count FSM stays in the top.

Test Plan:
- Reset held 2 cycles, then released with sh=0 -> all outputs 0, busy=0.
- WIDTH=4, LSB_FIRST=1, sh high 4 cycles, sin=1,0,1,1, dout_ready=1 -> dout=4'hD, dout_valid=1 for exactly 1 cycle after the burst, busy high for cycles 2-4 of the burst.
- LSB_FIRST=0, same stimulus -> dout=4'hB.
- sh high 2 cycles then low -> frame_err pulse 1 cycle, dout_valid stays 0; following full burst sin=0,1,1,0 -> dout=4'h6.
- dout_ready=0, two back-to-back bursts (8 sh-high cycles) sin 1,1,1,1,0,0,0,0 -> dout=4'hF held, overrun pulse after 8th cycle, dout_valid stays 1; then dout_ready=1 -> dout_valid drops.
- rst asserted after 2 bits of a burst, sh continues 2 more cycles -> no frame_err, no dout_valid; a fresh 4-cycle burst afterward is received correctly.

Source files
------------

// File: rtl/serial_link_pkg.sv
// Shared definitions for the shift-enable serial link: receiver state encoding
// and the default frame width used by both ends of the link.
package serial_link_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } link_state_t;

  localparam int FRAME_BITS = 4;

endpackage : serial_link_pkg

// File: rtl/serial_out_buffer.sv
// Single-entry valid/ready holding register for completed words. A word that
// arrives while the held word is still pending and not being taken is dropped.
module serial_out_buffer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] dout_r;
  logic             dout_valid_r;
  logic             overrun_r;

  // Holding register: accept, hand off, or drop with a one-cycle overrun pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      overrun_r <= 1'b0;
      if (load) begin
        // The slot frees up on the same edge it is consumed, so a new word can land
        if (!dout_valid_r || dout_ready) begin
          dout_r       <= word;
          dout_valid_r <= 1'b1;
        end else begin
          overrun_r <= 1'b1;
        end
      end else if (dout_valid_r && dout_ready) begin
        dout_valid_r <= 1'b0;
      end else begin
        dout_valid_r <= dout_valid_r;
      end
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign overrun    = overrun_r;

endmodule : serial_out_buffer

// File: rtl/serial_word_receiver.sv
// Deserializer for the shift-enable serial link: samples sin while sh is high,
// assembles WIDTH-bit frames and reports truncated bursts as framing errors.
module serial_word_receiver
  import serial_link_pkg::*;
#(
  parameter int WIDTH     = FRAME_BITS,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sh,
  input  logic             sin,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  ONE      = CW'(1);

  link_state_t      state_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] shreg_r;
  logic             busy_r;
  logic             frame_err_r;
  logic [WIDTH-1:0] shifted_s;
  logic             complete_s;

  // Next shift-register contents with the current sin folded in
  always_comb begin
    shifted_s = '0;
    if (LSB_FIRST) begin
      shifted_s = {sin, shreg_r[WIDTH-1:1]};
    end else begin
      shifted_s = {shreg_r[WIDTH-2:0], sin};
    end
  end

  // A frame completes on the edge that samples its last bit
  always_comb begin
    complete_s = 1'b0;
    if ((state_r == ST_SHIFT) && sh && (count_r == LAST_BIT)) begin
      complete_s = 1'b1;
    end else begin
      complete_s = 1'b0;
    end
  end

  // Frame FSM: bit counting, shifting and framing-error detection
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      count_r     <= '0;
      shreg_r     <= '0;
      busy_r      <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (sh) begin
            shreg_r <= shifted_s;
            count_r <= ONE;
            state_r <= ST_SHIFT;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (!sh) begin
            frame_err_r <= 1'b1;
            shreg_r     <= '0;
            count_r     <= '0;
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
          end else if (count_r == LAST_BIT) begin
            // Completed word goes to the output buffer via shifted_s
            shreg_r <= '0;
            count_r <= '0;
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            shreg_r <= shifted_s;
            count_r <= count_r + ONE;
            state_r <= ST_SHIFT;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          shreg_r <= '0;
          count_r <= '0;
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  serial_out_buffer #(
    .WIDTH(WIDTH)
  ) u_out_buffer (
    .clk        (clk),
    .rst        (rst),
    .load       (complete_s),
    .word       (shifted_s),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .overrun    (overrun)
  );

  assign busy      = busy_r;
  assign frame_err = frame_err_r;

endmodule : serial_word_receiver

// File: tb/tb_serial_word_receiver.sv
// Directed bench: an LSB-first and an MSB-first receiver share one stimulus
// stream; expected words are hand-computed for each bit order.
module tb_serial_word_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       sh;
  logic       sin;
  logic       dout_ready;
  logic [3:0] dout_l, dout_m;
  logic       valid_l, valid_m, busy_l, busy_m;
  logic       ferr_l, ferr_m, ovr_l, ovr_m;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_word_receiver #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .sh(sh), .sin(sin),
    .dout(dout_l), .dout_valid(valid_l), .dout_ready(dout_ready),
    .busy(busy_l), .frame_err(ferr_l), .overrun(ovr_l)
  );

  serial_word_receiver #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .sh(sh), .sin(sin),
    .dout(dout_m), .dout_valid(valid_m), .dout_ready(dout_ready),
    .busy(busy_m), .frame_err(ferr_m), .overrun(ovr_m)
  );

  task automatic check_eq(input string tag, input logic [31:0] observed,
                          input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of sh/sin, then sample just after the edge
  task automatic step(input logic s, input logic d);
    sh  = s;
    sin = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic v, input logic b,
                             input logic fe, input logic ov);
    check_eq({tag, "_valid"}, 32'(valid_l), 32'(v));
    check_eq({tag, "_busy"},  32'(busy_l),  32'(b));
    check_eq({tag, "_ferr"},  32'(ferr_l),  32'(fe));
    check_eq({tag, "_ovr"},   32'(ovr_l),   32'(ov));
    check_eq({tag, "_valid_m"}, 32'(valid_m), 32'(v));
    check_eq({tag, "_ferr_m"},  32'(ferr_m),  32'(fe));
    check_eq({tag, "_ovr_m"},   32'(ovr_m),   32'(ov));
  endtask

  initial begin
    rst = 1'b1; sh = 1'b0; sin = 1'b0; dout_ready = 1'b1;
    #2;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    rst = 1'b0;
    step(1'b0, 1'b0);
    check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("reset_dout_l", 32'(dout_l), 32'h0);
    check_eq("reset_dout_m", 32'(dout_m), 32'h0);

    // Full frame 1,0,1,1: LSB-first 0xD, MSB-first 0xB
    step(1'b1, 1'b1); check_flags("f1_b1", 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0); check_flags("f1_b2", 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1); check_flags("f1_b3", 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1); check_flags("f1_b4", 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("f1_dout_l", 32'(dout_l), 32'hD);
    check_eq("f1_dout_m", 32'(dout_m), 32'hB);
    step(1'b0, 1'b0); check_flags("f1_after", 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("f1_hold_l", 32'(dout_l), 32'hD);

    // Truncated burst, then frame 0,1,1,0 -> 0x6 in both orders
    step(1'b1, 1'b0);
    step(1'b1, 1'b1); check_flags("tr_b2", 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0); check_flags("tr_err", 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0); check_flags("tr_clr", 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0); check_flags("f2_done", 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("f2_dout_l", 32'(dout_l), 32'h6);
    check_eq("f2_dout_m", 32'(dout_m), 32'h6);
    step(1'b0, 1'b0);

    // Stalled consumer, back-to-back frames 1111 then 0000
    dout_ready = 1'b0;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1); check_flags("ov_w1", 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("ov_w1_dout", 32'(dout_l), 32'hF);
    step(1'b1, 1'b0); check_flags("ov_b2b", 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0); check_flags("ov_w2", 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("ov_keep_l", 32'(dout_l), 32'hF);
    check_eq("ov_keep_m", 32'(dout_m), 32'hF);
    step(1'b0, 1'b0); check_flags("ov_clr", 1'b1, 1'b0, 1'b0, 1'b0);
    dout_ready = 1'b1;
    step(1'b0, 1'b0); check_flags("ov_drain", 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("ov_drain_dout", 32'(dout_l), 32'hF);

    // Reset mid-frame discards the partial word silently
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    rst = 1'b1;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1); check_flags("mr_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("mr_dout", 32'(dout_l), 32'h0);
    rst = 1'b0;
    step(1'b0, 1'b0); check_flags("mr_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    // Frame 1,1,0,0: LSB-first 0x3, MSB-first 0xC
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0); check_flags("f3_done", 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("f3_dout_l", 32'(dout_l), 32'h3);
    check_eq("f3_dout_m", 32'(dout_m), 32'hC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_word_receiver
